// File: rtl/stage_memory.sv
// Pipeline MEM stage: data-memory access over req/gnt/rvalid with byte-lane steering,
// load extension, misalignment/timeout faults and the MEM/WB result register.
module stage_memory #(
    parameter logic [1:0]  LOAD_SRC       = 2'b01,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] execute_alu_result,
    input  logic [31:0] execute_wr_datamem_data,
    input  logic        execute_datamem_wr_enable,
    input  logic [1:0]  execute_result_src,
    input  logic [2:0]  execute_funct3,
    input  logic [4:0]  execute_rd,
    input  logic        execute_regfile_wr_enable,
    input  logic [31:0] execute_instr_addr_plus,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  mem_rd,
    output logic        mem_regfile_wr_enable,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_read_data,
    output logic [1:0]  mem_result_src,
    output logic [31:0] mem_instr_addr_plus,
    output logic        mem_misaligned,
    output logic        mem_bus_error
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: access_legal = 1'b1;
            3'b001, 3'b101: access_legal = ~off[0];
            3'b010:         access_legal = (off == 2'b00);
            default:        access_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h0, b};
            3'b101:  load_extend = {16'h0, h};
            default: load_extend = rdata;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req, stall, abort, load_done;

    logic is_store, is_load, access, legal, misaligned;

    assign is_store   = execute_datamem_wr_enable;
    assign is_load    = ~is_store && (execute_result_src == LOAD_SRC);
    assign access     = is_store || is_load;
    assign legal      = access_legal(execute_funct3, execute_alu_result[1:0]);
    assign misaligned = access && ~legal;

    // Address and lane steering depend only on the (frozen) execute inputs, so
    // they stay stable for the whole life of an outstanding request.
    assign dmem_we    = is_store;
    assign dmem_addr  = {execute_alu_result[31:2], 2'b00};
    assign dmem_be    = lane_be(execute_funct3[1:0], execute_alu_result[1:0]);
    assign dmem_wdata = lane_wdata(execute_funct3[1:0], execute_wr_datamem_data);
    assign dmem_req   = req & rst_n;
    assign mem_stall  = stall & rst_n;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req       = 1'b0;
        stall     = 1'b0;
        abort     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && legal) begin
                    req = 1'b1;
                    if (!dmem_gnt) begin
                        state_d = WAIT_GNT;
                        cnt_d   = 8'd0;
                        stall   = 1'b1;
                    end else if (is_load) begin
                        state_d = WAIT_RVALID;
                        cnt_d   = 8'd0;
                        stall   = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (dmem_gnt) begin
                    if (is_load) begin
                        state_d = WAIT_RVALID;
                        cnt_d   = 8'd0;
                        stall   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    stall = 1'b1;
                end
            end
            WAIT_RVALID: begin
                if (dmem_rvalid) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stalled edges insert a bubble: write enable and fault pulses clear, data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd                <= 5'd0;
            mem_regfile_wr_enable <= 1'b0;
            mem_alu_result        <= 32'd0;
            mem_read_data         <= 32'd0;
            mem_result_src        <= 2'd0;
            mem_instr_addr_plus   <= 32'd0;
            mem_misaligned        <= 1'b0;
            mem_bus_error         <= 1'b0;
        end else if (stall) begin
            mem_regfile_wr_enable <= 1'b0;
            mem_misaligned        <= 1'b0;
            mem_bus_error         <= 1'b0;
        end else begin
            mem_rd                <= execute_rd;
            mem_regfile_wr_enable <= execute_regfile_wr_enable & ~misaligned & ~abort;
            mem_alu_result        <= execute_alu_result;
            mem_result_src        <= execute_result_src;
            mem_instr_addr_plus   <= execute_instr_addr_plus;
            mem_misaligned        <= misaligned;
            mem_bus_error         <= abort;
            if (load_done) begin
                mem_read_data <= load_extend(execute_funct3, execute_alu_result[1:0], dmem_rdata);
            end
        end
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline MEM stage, directly downstream of the execute stage. Consumes the execute-stage register outputs.
- Performs loads and stores over a req/gnt/rvalid data-memory bus: byte-lane steering, load sign/zero extension, misalignment detection, bus timeout.
- Asserts a stall back to IF/ID/EX while an access is outstanding.
- Registers results for writeback and feeds the mem_* forwarding paths of execute.

Parameters:
- LOAD_SRC, 2'b01, execute_result_src encoding that marks a load.
- TIMEOUT_CYCLES, 255, max cycles waiting for gnt or for rvalid before abort (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- execute_alu_result  in  32  effective address / ALU result
- execute_wr_datamem_data  in  32  store data (rs2)
- execute_datamem_wr_enable  in  1  store
- execute_result_src  in  2  result select; LOAD_SRC = load
- execute_funct3  in  3  access size/sign
- execute_rd  in  5  destination register
- execute_regfile_wr_enable  in  1  regfile write
- execute_instr_addr_plus  in  32  PC+4
- mem_stall  out  1  combinational; freeze IF/ID/EX this cycle
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {alu_result[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- mem_rd  out  5  registered rd
- mem_regfile_wr_enable  out  1  registered write enable
- mem_alu_result  out  32  registered ALU result
- mem_read_data  out  32  registered extended load data
- mem_result_src  out  2  registered result select
- mem_instr_addr_plus  out  32  registered PC+4
- mem_misaligned  out  1  one-cycle pulse, faulting access dropped
- mem_bus_error  out  1  one-cycle pulse, access timed out

Behaviour:
- Access op = execute_datamem_wr_enable, or execute_result_src==LOAD_SRC. Other instructions pass through with one-cycle latency and no stall.
- Alignment:
  - funct3[1:0] 00 byte: always legal.
  - funct3[1:0] 01 half: illegal when addr[0]=1.
  - funct3[1:0] 10 word: illegal when addr[1:0]!=0.
  - funct3 011/110/111: illegal.
  - Illegal access: no dmem_req, no stall. Next edge registers mem_misaligned=1 and mem_regfile_wr_enable=0.
- Stores:
  - be: SB = 0001<<addr[1:0], SH = 0011<<{addr[1],1'b0}, SW = 1111.
  - wdata: byte replicated x4, half x2, word as-is.
- Loads: select lane by addr[1:0] from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW raw.
  - be is driven as for stores.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE + legal access:
  - dmem_req=1 combinationally.
  - gnt=1 and store: complete this cycle, no stall.
  - gnt=1 and load: go to WAIT_RVALID, stall=1.
  - gnt=0: go to WAIT_GNT, stall=1.
- WAIT_GNT:
  - dmem_req held with stable addr/be/wdata/we.
  - On gnt: store completes (stall=0, back to IDLE); load goes to WAIT_RVALID.
- WAIT_RVALID:
  - dmem_req=0.
  - On rvalid: stall=0, data captured into mem_read_data at that edge, back to IDLE.
  - rvalid in the grant cycle itself is ignored.
- Timeout:
  - 8-bit counter cleared on entry to WAIT_GNT or WAIT_RVALID, incremented each waiting cycle.
  - When count==TIMEOUT_CYCLES-1 without the awaited signal: abort, stall=0, return to IDLE.
  - Registers mem_bus_error=1 and mem_regfile_wr_enable=0.
  - A late rvalid in IDLE is ignored.
- Output register update:
  - Each edge with mem_stall=0 loads the execute inputs.
  - Each edge with mem_stall=1 loads a bubble: mem_regfile_wr_enable=0, mem_misaligned=0, mem_bus_error=0; other fields hold.
  - mem_misaligned and mem_bus_error are zero except on the faulting instruction's edge.
- Execute inputs are stable while mem_stall=1, because upstream is frozen.
- Reset (async, any state): state IDLE, counter 0, all registered outputs 0, dmem_req forced 0 while rst_n=0. Outstanding bus responses after reset are ignored.

Test Plan:
- ADD, rd=5, alu_result=0x1234 -> next edge mem_rd=5, mem_alu_result=0x1234, mem_regfile_wr_enable=1; stall never asserted.
- SB addr=0x103, data=0xAB, gnt same cycle -> dmem_addr=0x100, be=1000, wdata=0xABABABAB; stall=0.
- LH addr=0x202, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x8001_0000 -> stall high 5 cycles; mem_read_data=0xFFFF8001 with wr_enable=1 on the completion edge; LHU of the same data -> 0x00008001.
- LW addr=0x101 -> no dmem_req, no stall; mem_misaligned pulses 1 cycle, mem_regfile_wr_enable=0.
- Load, gnt=1, rvalid never, TIMEOUT_CYCLES=4 -> stall 4 cycles; mem_bus_error pulse, wr_enable=0, FSM IDLE; a later stray rvalid has no effect.
- rst_n low while in WAIT_RVALID -> dmem_req=0 and all outputs 0 immediately; after release, ADD passes normally.
